// File: rtl/csa_mul_front.sv
// rtl/csa_mul_front.sv - sequential carry-save multiplier front end (optional macro CSA_MUL_EARLY_EXIT_EN)
module csa_mul_front #(
   parameter int W     = 5,
   parameter int CNT_W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_a,
   output logic [W-1:0] out_b
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [W-1:0]       sum_q;
   logic [W-1:0]       carry_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [W-1:0]       pp;
   logic [W-1:0]       maj;
   logic [W-1:0]       sum_n;
   logic [W-1:0]       carry_n;
   logic               last_step;
   logic               accept;
   logic               step;
   logic               load;

   // One 3:2 compression of the running (sum, carry) pair with the current partial product
   always_comb begin
      pp      = '0;
      if (((b_q >> cnt_q) & W'(1)) != '0) begin
         pp = a_q << cnt_q;
      end
      sum_n   = sum_q ^ carry_q ^ pp;
      maj     = (sum_q & carry_q) | (sum_q & pp) | (carry_q & pp);
      carry_n = {maj[W-2:0], 1'b0};
   end

`ifdef CSA_MUL_EARLY_EXIT_EN
   logic [CNT_W:0] cnt_inc;

   // Finish as soon as no multiplier bits remain above the one just consumed
   always_comb begin
      cnt_inc   = {1'b0, cnt_q} + (CNT_W+1)'(1);
      last_step = (cnt_q == CNT_W'(W-1)) || ((b_q >> cnt_inc) == '0);
   end
`else
   // Always walk every multiplier bit so latency is operand independent
   always_comb begin
      last_step = (cnt_q == CNT_W'(W-1));
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake decode
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      step      = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            step = 1'b1;
            if (last_step) begin
               load      = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture, accumulation and result registers; results persist after handoff
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= '0;
         cnt_q   <= '0;
         out_a   <= '0;
         out_b   <= '0;
      end else begin
         if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
         end else if (step) begin
            sum_q   <= sum_n;
            carry_q <= carry_n;
            cnt_q   <= cnt_q + CNT_W'(1);
         end
         if (load) begin
            out_a <= sum_n;
            out_b <= carry_n;
         end
      end
   end

endmodule
